alu_decode_mdu: RTL and testbench
=================================

// Module: alu_decode_mdu
// PURPOSE
//  Next-generation ALU decoder for the MIPS core with a multi-cycle multiply unit (MDU).
//  Decodes ALU_OP/FUNCT to a CTRL_W-bit ALU_CONTROL, launches MULT/MULTU on an iterative
//  shift-add multiplier, holds HI/LO and stalls the pipeline on MDU hazards.
//  Sits in the execute stage between the main control unit and the ALU/HI-LO read mux.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are each WIDTH bits
//  CTRL_W  4   ALU_CONTROL width, >=4; codes are zero-extended to CTRL_W
// PORTS
//  CLK          in   1       clock, all state on rising edge
//  RST          in   1       asynchronous active-low reset
//  VALID_IN     in   1       instruction in execute stage is valid
//  FLUSH        in   1       abort any MDU operation in progress
//  ALU_OP       in   2       op class from main control
//  FUNCT        in   6       R-type funct field
//  SRC_A        in   WIDTH   multiplicand (rs)
//  SRC_B        in   WIDTH   multiplier (rt)
//  ALU_CONTROL  out  CTRL_W  ALU operation select (combinational)
//  STALL        out  1       hold the front of the pipeline this cycle (combinational)
//  MDU_BUSY     out  1       MDU in RUN or DONE
//  MDU_DONE     out  1       one-cycle pulse: HI/LO written at the end of this cycle
//  HI           out  WIDTH   upper product word (registered)
//  LO           out  WIDTH   lower product word (registered)
// BEHAVIOUR
//  Decode (combinational):
//   ALU_OP 00 -> ADD 0010; 01 -> SUB 0100; 11 -> ADD.
//   ALU_OP 10, by FUNCT: 100000 ADD; 100010 SUB; 101010 SLT 0110; 011100 MUL 0101;
//   100100 AND 0000; 100101 OR 0001; 010000 MFHI 0111; 010010 MFLO 1000;
//   011000 MULT / 011001 MULTU -> NOP 1001; any other FUNCT -> ADD.
//  Hazard: STALL = VALID_IN & (MULT|MULTU|MFHI|MFLO) & MDU_BUSY.
//   Other ops never stall. A stalled op is re-presented by the pipeline.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: a MULT/MULTU accepted (VALID_IN & !STALL) -> RUN.
//    On accept, latch the operands: MULT latches |SRC_A|, |SRC_B| as WIDTH-bit unsigned
//    plus sign = a_msb ^ b_msb. MULTU latches the raw values with sign = 0.
//    Clear the 2*WIDTH accumulator; cnt = WIDTH.
//   RUN: each cycle, if multiplier LSB = 1, add the multiplicand to accumulator[2W-1:W]
//    with carry kept. Then shift {carry,acc} right by 1, shift the multiplier right and
//    decrement cnt. After WIDTH RUN cycles -> DONE.
//   DONE: {HI,LO} <= sign ? -acc : acc; MDU_DONE = 1; -> IDLE.
//  Latency: MULT accepted at edge k; HI/LO valid after edge k+WIDTH+1.
//   MDU_BUSY is high for WIDTH+1 cycles.
//  Corner: -2^(W-1) x -2^(W-1) = 2^(2W-2) (magnitude fits W unsigned bits); x0 -> 0.
//  FLUSH in RUN or DONE: -> IDLE next edge; HI/LO unchanged; no MDU_DONE.
//   FLUSH has priority over DONE's write. FLUSH in IDLE blocks acceptance that cycle.
//  MFHI/MFLO during DONE stall; the next cycle reads the new HI/LO.
//  Reset (RST=0, any state): state IDLE, HI=LO=0, acc=0, cnt=0, MDU_BUSY=0, MDU_DONE=0.
//   Reset mid-RUN discards the operation.
//  ALU_CONTROL and STALL depend only on inputs and MDU_BUSY; no reset value of their own.
// STRUCTURE
//  alu_ctrl_pkg: ALU_CONTROL code constants, FUNCT/ALU_OP constants, FSM state enum.
//  One sub-module: mdu_seq_mult (FSM, counter, accumulator, sign fix-up, HI/LO regs).
//  Top: decode logic, MULT/MFHI/MFLO detect, STALL, mdu_seq_mult instance.
// TESTING
//  Decode sweep: every ALU_OP/FUNCT above plus FUNCT 111111 -> listed code; 111111 -> 0010.
//  MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001,
//   one MDU_DONE pulse.
//  MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB;
//   MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
//  MFLO issued 5 cycles after MULT -> STALL high until DONE cycle completes,
//   then ALU_CONTROL=1000 with new LO.
//  FLUSH at RUN cycle 10 of MULT 2x3 (prior HI/LO=0) -> IDLE, no MDU_DONE, HI=LO=0;
//   next MULT accepted at once.
//  RST low at RUN cycle 20 -> HI=LO=0, MDU_BUSY=0 immediately; ADD after release: no stall.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Purpose: shared ALU_CONTROL codes, ALU_OP/FUNCT encodings and MDU FSM state type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Ports: none.
package alu_ctrl_pkg;

  // ALU_CONTROL codes (4-bit, zero-extended by the decoder to CTRL_W)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_MFHI = 4'b0111;
  localparam logic [3:0] ALU_MFLO = 4'b1000;
  localparam logic [3:0] ALU_NOP  = 4'b1001;

  // ALU_OP classes from the main control unit
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // R-type FUNCT encodings
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MUL   = 6'b011100;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq_mult.sv
// Purpose: iterative shift-add multiplier with sign fix-up and HI/LO result registers.
// Latency: start at edge k -> HI/LO written at edge k+WIDTH+1; busy for WIDTH+1 cycles.
// Backpressure: no new start while busy (caller stalls); flush aborts without writing HI/LO.
// Ports: clk, rst_n (async active-low), start/is_signed/src_a/src_b launch an op,
//        flush aborts, busy/done status, hi/lo registered product words.
module mdu_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import alu_ctrl_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush wins over both RUN progress and the DONE write
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)                     state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(1))   state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE) && !flush;
  end

  // Datapath
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    // Carry out of the upper half is kept as bit WIDTH and shifted back in below
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    product  = sign_q ? -acc_q : acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Signed ops multiply magnitudes; -2^(W-1) negates to itself, which is the
          // correct unsigned magnitude
          mcand_d  = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
          mplier_d = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
          sign_d   = is_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
        end
      end
      ST_RUN: begin
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        if (!flush) {hi_d, lo_d} = product;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/alu_decode_mdu.sv
// Purpose: execute-stage ALU decoder with MULT/MULTU launch into a sequential MDU and hazard stall.
// Latency: ALU_CONTROL/STALL combinational; HI/LO valid WIDTH+1 edges after MULT accept.
// Backpressure: STALL holds MULT/MULTU/MFHI/MFLO while the MDU is busy; the pipeline re-presents.
// Ports: CLK, RST (async active-low), VALID_IN, FLUSH, ALU_OP, FUNCT, SRC_A, SRC_B in;
//        ALU_CONTROL, STALL, MDU_BUSY, MDU_DONE, HI, LO out.
module alu_decode_mdu #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VALID_IN,
  input  logic              FLUSH,
  input  logic [1:0]        ALU_OP,
  input  logic [5:0]        FUNCT,
  input  logic [WIDTH-1:0]  SRC_A,
  input  logic [WIDTH-1:0]  SRC_B,
  output logic [CTRL_W-1:0] ALU_CONTROL,
  output logic              STALL,
  output logic              MDU_BUSY,
  output logic              MDU_DONE,
  output logic [WIDTH-1:0]  HI,
  output logic [WIDTH-1:0]  LO
);
  import alu_ctrl_pkg::*;

  logic [3:0] ctrl;
  logic       is_rtype, is_mult, is_multu, is_mfhi, is_mflo;
  logic       mdu_op, mdu_start;

  always_comb begin
    ctrl = ALU_ADD;
    case (ALU_OP)
      ALUOP_MEM:   ctrl = ALU_ADD;
      ALUOP_BR:    ctrl = ALU_SUB;
      ALUOP_IMM:   ctrl = ALU_ADD;
      ALUOP_RTYPE: begin
        case (FUNCT)
          FUNCT_ADD:   ctrl = ALU_ADD;
          FUNCT_SUB:   ctrl = ALU_SUB;
          FUNCT_SLT:   ctrl = ALU_SLT;
          FUNCT_MUL:   ctrl = ALU_MUL;
          FUNCT_AND:   ctrl = ALU_AND;
          FUNCT_OR:    ctrl = ALU_OR;
          FUNCT_MFHI:  ctrl = ALU_MFHI;
          FUNCT_MFLO:  ctrl = ALU_MFLO;
          FUNCT_MULT:  ctrl = ALU_NOP;
          FUNCT_MULTU: ctrl = ALU_NOP;
          default:     ctrl = ALU_ADD;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  assign ALU_CONTROL = CTRL_W'(ctrl);

  assign is_rtype = (ALU_OP == ALUOP_RTYPE);
  assign is_mult  = is_rtype && (FUNCT == FUNCT_MULT);
  assign is_multu = is_rtype && (FUNCT == FUNCT_MULTU);
  assign is_mfhi  = is_rtype && (FUNCT == FUNCT_MFHI);
  assign is_mflo  = is_rtype && (FUNCT == FUNCT_MFLO);
  assign mdu_op   = is_mult || is_multu || is_mfhi || is_mflo;

  // HI/LO readers also stall during DONE so they see the freshly written product
  assign STALL     = VALID_IN && mdu_op && MDU_BUSY;
  assign mdu_start = VALID_IN && (is_mult || is_multu) && !STALL && !FLUSH;

  mdu_seq_mult #(.WIDTH(WIDTH)) u_mdu (
    .clk       (CLK),
    .rst_n     (RST),
    .start     (mdu_start),
    .is_signed (is_mult),
    .flush     (FLUSH),
    .src_a     (SRC_A),
    .src_b     (SRC_B),
    .busy      (MDU_BUSY),
    .done      (MDU_DONE),
    .hi        (HI),
    .lo        (LO)
  );

endmodule

// File: tb/tb_alu_decode_mdu.sv
module tb_alu_decode_mdu;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         VALID_IN = 1'b0;
  logic         FLUSH = 1'b0;
  logic [1:0]   ALU_OP = 2'b00;
  logic [5:0]   FUNCT = 6'b0;
  logic [W-1:0] SRC_A = '0;
  logic [W-1:0] SRC_B = '0;
  logic [3:0]   ALU_CONTROL;
  logic         STALL, MDU_BUSY, MDU_DONE;
  logic [W-1:0] HI, LO;

  int total = 0;
  int bad = 0;

  logic [63:0] exp_q[$];
  logic [3:0]  dec_q[$];
  bit          dec_chk = 0;
  bit          pend = 0;
  int          done_cnt = 0;

  alu_decode_mdu #(.WIDTH(W), .CTRL_W(4)) dut (
    .CLK(CLK), .RST(RST), .VALID_IN(VALID_IN), .FLUSH(FLUSH),
    .ALU_OP(ALU_OP), .FUNCT(FUNCT), .SRC_A(SRC_A), .SRC_B(SRC_B),
    .ALU_CONTROL(ALU_CONTROL), .STALL(STALL), .MDU_BUSY(MDU_BUSY),
    .MDU_DONE(MDU_DONE), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: decode results while dec_chk is set; HI/LO one cycle after each MDU_DONE pulse
  always @(negedge CLK) begin
    if (dec_chk) begin
      if (dec_q.size() == 0) begin
        total++; bad++;
        $display("FAIL decode_underflow: got ctrl %h with no expected entry", ALU_CONTROL);
      end else begin
        check("decode", 64'(ALU_CONTROL), 64'(dec_q.pop_front()));
      end
    end
    if (pend) begin
      pend = 0;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got hi_lo %h with no expected product", {HI, LO});
      end else begin
        check("hi_lo", {HI, LO}, exp_q.pop_front());
      end
    end
    if (MDU_DONE) begin
      done_cnt++;
      pend = 1;
    end
  end

  // Presents a MULT/MULTU for one cycle and confirms it was accepted; ends at the
  // falling edge of RUN cycle 1.
  task automatic start_mul(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit push, input logic [63:0] exp);
    @(posedge CLK); #1;
    VALID_IN = 1'b1; ALU_OP = 2'b10; FUNCT = sgn ? 6'b011000 : 6'b011001;
    SRC_A = a; SRC_B = b;
    if (push) exp_q.push_back(exp);
    @(posedge CLK); #1;
    VALID_IN = 1'b0; ALU_OP = 2'b00; FUNCT = 6'b0;
    @(negedge CLK);
    check("accept_busy", 64'(MDU_BUSY), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int cyc = 1;
    int d0 = done_cnt;
    while (!MDU_DONE && cyc < 80) begin
      @(negedge CLK);
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(W + 1));
    @(negedge CLK); #1;
    check({name, "_busy_low"}, 64'(MDU_BUSY), 64'd0);
    check({name, "_one_done"}, 64'(done_cnt - d0), 64'd1);
  endtask

  logic [1:0] v_op  [14] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10,
                             2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [5:0] v_fn  [14] = '{6'b100010, 6'b100000, 6'b101010, 6'b100000, 6'b100010,
                             6'b101010, 6'b011100, 6'b100100, 6'b100101, 6'b010000,
                             6'b010010, 6'b011000, 6'b011001, 6'b111111};
  logic [3:0] v_exp [14] = '{4'b0010, 4'b0100, 4'b0010, 4'b0010, 4'b0100, 4'b0110,
                             4'b0101, 4'b0000, 4'b0001, 4'b0111, 4'b1000, 4'b1001,
                             4'b1001, 4'b0010};

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;

    // Reset state
    #12;
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    check("rst_busy", 64'(MDU_BUSY), 64'd0);
    check("rst_done", 64'(MDU_DONE), 64'd0);
    @(negedge CLK); RST = 1'b1;

    // Decode sweep (VALID_IN low so MULT/MULTU do not launch)
    for (int i = 0; i < 14; i++) begin
      @(posedge CLK); #1;
      ALU_OP = v_op[i]; FUNCT = v_fn[i];
      dec_q.push_back(v_exp[i]);
      dec_chk = 1;
    end
    @(posedge CLK); #1;
    dec_chk = 0; ALU_OP = 2'b00; FUNCT = 6'b0;

    // FLUSH in IDLE blocks acceptance
    @(posedge CLK); #1;
    VALID_IN = 1'b1; ALU_OP = 2'b10; FUNCT = 6'b011000; SRC_A = 32'd2; SRC_B = 32'd3; FLUSH = 1'b1;
    @(posedge CLK); #1;
    VALID_IN = 1'b0; FLUSH = 1'b0; ALU_OP = 2'b00; FUNCT = 6'b0;
    @(negedge CLK);
    check("flush_idle_no_accept", 64'(MDU_BUSY), 64'd0);

    // MULT 2x3 flushed at RUN cycle 10, with stall probes along the way
    d0 = done_cnt;
    start_mul(1'b1, 32'd2, 32'd3, 1'b0, 64'd0);
    @(posedge CLK); #1;
    VALID_IN = 1'b1; ALU_OP = 2'b10; FUNCT = 6'b100000;
    @(negedge CLK);
    check("add_busy_no_stall", 64'(STALL), 64'd0);
    check("add_busy_ctrl", 64'(ALU_CONTROL), 64'h2);
    @(posedge CLK); #1;
    FUNCT = 6'b010000;
    @(negedge CLK);
    check("mfhi_busy_stall", 64'(STALL), 64'd1);
    check("mfhi_busy_ctrl", 64'(ALU_CONTROL), 64'h7);
    @(posedge CLK); #1;
    VALID_IN = 1'b0; ALU_OP = 2'b00; FUNCT = 6'b0;
    repeat (6) @(posedge CLK);
    #1 FLUSH = 1'b1;
    @(negedge CLK);
    check("flush_cycle_busy", 64'(MDU_BUSY), 64'd1);
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    @(negedge CLK);
    check("flush_busy", 64'(MDU_BUSY), 64'd0);
    check("flush_hi_lo", {HI, LO}, 64'd0);
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);
    start_mul(1'b1, 32'd2, 32'd3, 1'b1, 64'd6);
    wait_done("mult_2x3");

    // MULTU max x max
    start_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    wait_done("multu_max");

    // MULT -3 x 7
    start_mul(1'b1, 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done("mult_neg3x7");

    // MFLO five cycles after a MULT stalls until the DONE cycle completes
    d0 = done_cnt;
    start_mul(1'b1, 32'd5, 32'd6, 1'b1, 64'd30);
    repeat (4) @(posedge CLK);
    #1;
    VALID_IN = 1'b1; ALU_OP = 2'b10; FUNCT = 6'b010010;
    n = 0;
    @(negedge CLK);
    while (STALL && n < 80) begin
      n++;
      @(negedge CLK);
    end
    #1;
    check("mflo_stall_cycles", 64'(n), 64'(W - 3));
    check("mflo_stall_released", 64'(STALL), 64'd0);
    check("mflo_ctrl", 64'(ALU_CONTROL), 64'h8);
    check("mflo_lo", 64'(LO), 64'd30);
    check("mflo_one_done", 64'(done_cnt - d0), 64'd1);
    @(posedge CLK); #1;
    VALID_IN = 1'b0; ALU_OP = 2'b00; FUNCT = 6'b0;

    // Most-negative squared
    start_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    wait_done("mult_minsq");

    // Reset at RUN cycle 20
    d0 = done_cnt;
    start_mul(1'b1, 32'd5, 32'd7, 1'b0, 64'd0);
    repeat (19) @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    check("rst_run_hi", 64'(HI), 64'd0);
    check("rst_run_lo", 64'(LO), 64'd0);
    check("rst_run_busy", 64'(MDU_BUSY), 64'd0);
    check("rst_run_done", 64'(MDU_DONE), 64'd0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    VALID_IN = 1'b1; ALU_OP = 2'b10; FUNCT = 6'b100000;
    @(negedge CLK);
    check("post_rst_add_stall", 64'(STALL), 64'd0);
    check("post_rst_add_ctrl", 64'(ALU_CONTROL), 64'h2);
    repeat (40) @(negedge CLK);
    check("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
    VALID_IN = 1'b0;

    @(negedge CLK);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("dec_q_drained", 64'(dec_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
